rosc_reader: RTL and testbench
==============================

Name: rosc_reader

Overview:
- Bus initiator that drains the ring-oscillator entropy source over the core register interface (cs/we/address/read_data/ready).
- Polls the source STATUS register until its ready bit is set, then reads the ENTROPY word. Each read clears the source's bit counter and ready flag.
- Buffers harvested words in a small FIFO and offers them on a valid/ready stream to a consumer such as a DRBG seeder.
- Runs a repetition-count health test on consecutive words.

Parameters:
- FIFO_DEPTH, 4: entry count; power of two, minimum 2.
- POLL_GAP, 16: idle cycles between STATUS polls that return not-ready; range 0..255.
- DISCARD_WORDS, 1: words read and dropped after reset or after enable rises; range 0..15.
- ADDR_STATUS, 8'h09: source STATUS register address.
- ADDR_ENTROPY, 8'h20: source ENTROPY register address.

Ports:
- clk  in  1  system clock.
- reset_n  in  1  asynchronous active-low reset.
- enable  in  1  harvesting enabled.
- cs  out  1  bus select to the entropy source.
- we  out  1  bus write enable; always 0.
- address  out  8  bus address.
- write_data  out  32  always 32'h0.
- read_data  in  32  bus read data.
- ready  in  1  bus completion.
- entropy_valid  out  1  stream word available.
- entropy_data  out  32  stream word.
- entropy_ready  in  1  consumer accepts the word.
- fill_level  out  $clog2(FIFO_DEPTH)+1  FIFO occupancy.
- repeat_error  out  1  sticky health-test failure.

Behaviour:
- Reset (asynchronous, reset_n=0):
  - cs, we, address, write_data = 0.
  - entropy_valid = 0, fill_level = 0, repeat_error = 0.
  - FSM goes to IDLE; discard counter loads DISCARD_WORDS; last-word register = 0.
- Bus rules:
  - cs and address are registered and held until ready is sampled high.
  - read_data is captured in the cycle ready=1; cs drops on the next edge.
  - No back-to-back cs: at least one cs=0 cycle between transactions.
  - The source returns ready in the same cycle as cs, so a normal transaction is 1 cycle plus 1 gap cycle.
  - There is no ready timeout; the FSM waits indefinitely for ready.
- FSM states:
  - IDLE: if enable and FIFO not full -> POLL.
  - POLL: cs=1, address=ADDR_STATUS. On ready: if read_data[0] -> READ, else -> GAP.
  - GAP: count POLL_GAP cycles, then -> IDLE. POLL_GAP=0 means exactly one cycle in GAP.
  - READ: cs=1, address=ADDR_ENTROPY. On ready, capture the word:
    - if discard counter != 0, decrement it and drop the word;
    - otherwise run the health test and push the word into the FIFO.
    - Then -> IDLE.
- FIFO-full gating: a full FIFO is checked only in IDLE. READ is entered only after a non-full check, and the single initiator cannot race itself, so a push can never overflow.
- enable deasserted:
  - Takes effect in IDLE and GAP (return to IDLE).
  - An in-flight POLL or READ always completes and its word is kept.
  - A 0->1 edge on enable reloads the discard counter.
- Health test:
  - A pushed word equal to the previously pushed word increments the repeat counter; a differing word clears it.
  - repeat_error sets when the counter reaches 2, i.e. three identical consecutive words.
  - repeat_error is cleared only by reset. Harvesting continues while it is set.
  - Discarded words do not update the last-word register.
- Stream:
  - entropy_data is the FIFO head (first-word-fall-through); entropy_valid = !empty.
  - A pop occurs when entropy_valid && entropy_ready.
  - Push and pop in the same cycle with the FIFO non-empty: fill_level unchanged.
  - Push into an empty FIFO: entropy_valid rises the cycle after the push.
- Pointers wrap modulo FIFO_DEPTH; full/empty are derived from an extra pointer bit.

Decomposition:
- Shared package rosc_pkg:
  - ADDR_STATUS, ADDR_ENTROPY, STATUS_READY_BIT; the entropy source also uses these.
  - FSM state encoding for IDLE, POLL, GAP, READ.
  - Health-test cutoff constant REPEAT_CUTOFF=2.
- One sub-module: rosc_reader_fifo, a synchronous FWFT FIFO with parameter DEPTH.

Test Plan:
- Source model answers STATUS=0 three times, then 1, then ENTROPY=32'hA5A5_0001, with DISCARD_WORDS=0 -> exactly 4 STATUS polls spaced POLL_GAP+2 cycles apart, 1 ENTROPY read, entropy_data=32'hA5A5_0001, fill_level=1.
- DISCARD_WORDS=1, source words 32'h1111_1111 then 32'h2222_2222 -> only 32'h2222_2222 appears on the stream.
- entropy_ready=0 with source always ready -> exactly 4 ENTROPY reads, fill_level=4, cs stays 0. Then one pop -> exactly one more ENTROPY read.
- Source returns 32'hDEAD_BEEF three times in a row -> repeat_error=1 after the third push. Words 32'hDEAD_BEEF, 32'h0, 32'hDEAD_BEEF -> repeat_error stays 0.
- reset_n low while cs=1 in READ -> cs=0 asynchronously, FIFO empty. After release with enable=1, the first transaction is a STATUS poll.
- Consumer holds entropy_ready=1 while pushes occur -> fill_level stays at most 1, and word order is preserved across 10 words.

Source files
------------

// File: rtl/rosc_pkg.sv
// Shared definitions for the ring-oscillator entropy reader and the entropy source register map.
package rosc_pkg;

   localparam logic [7:0]  ADDR_STATUS      = 8'h09;
   localparam logic [7:0]  ADDR_ENTROPY     = 8'h20;
   localparam int unsigned STATUS_READY_BIT = 0;
   localparam int unsigned DATA_W           = 32;
   localparam int unsigned ADDR_W           = 8;

   // Three identical consecutive words trip the health test.
   localparam int unsigned REPEAT_CUTOFF    = 2;
   localparam int unsigned REP_CNT_W        = 2;

   typedef enum logic [1:0] {
      ST_IDLE = 2'd0,
      ST_POLL = 2'd1,
      ST_GAP  = 2'd2,
      ST_READ = 2'd3
   } rosc_state_t;

   function automatic logic [REP_CNT_W-1:0] rep_cnt_next(
      input logic [REP_CNT_W-1:0] cnt
   );
      if (cnt >= REP_CNT_W'(REPEAT_CUTOFF)) begin
         return REP_CNT_W'(REPEAT_CUTOFF);
      end
      return cnt + REP_CNT_W'(1);
   endfunction

   function automatic logic rep_trips(input logic [REP_CNT_W-1:0] cnt);
      return (cnt >= REP_CNT_W'(REPEAT_CUTOFF - 1));
   endfunction

endpackage

// File: rtl/rosc_reader_fifo.sv
// First-word-fall-through FIFO; full/empty come from an extra wrap bit on each pointer.
module rosc_reader_fifo #(
   parameter int unsigned DEPTH = 4,
   parameter int unsigned WIDTH = 32
) (
   input  logic                       clk,
   input  logic                       reset_n,
   input  logic                       i_push,
   input  logic [WIDTH-1:0]           i_data,
   input  logic                       i_pop,
   output logic [WIDTH-1:0]           o_data,
   output logic                       o_empty,
   output logic                       o_full,
   output logic [$clog2(DEPTH):0]     o_level
);

   localparam int unsigned AW = $clog2(DEPTH);

   logic [WIDTH-1:0] r_mem [DEPTH];
   logic [AW:0]      r_wr_ptr;
   logic [AW:0]      r_rd_ptr;
   logic             w_do_push;
   logic             w_do_pop;

   assign o_empty   = (r_wr_ptr == r_rd_ptr);
   assign o_full    = (r_wr_ptr[AW] != r_rd_ptr[AW]) &&
                      (r_wr_ptr[AW-1:0] == r_rd_ptr[AW-1:0]);
   assign o_level   = r_wr_ptr - r_rd_ptr;
   assign o_data    = r_mem[r_rd_ptr[AW-1:0]];
   assign w_do_push = i_push && !o_full;
   assign w_do_pop  = i_pop && !o_empty;

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         r_wr_ptr <= '0;
         r_rd_ptr <= '0;
         for (int i = 0; i < int'(DEPTH); i++) begin
            r_mem[i] <= '0;
         end
      end else begin
         if (w_do_push) begin
            r_mem[r_wr_ptr[AW-1:0]] <= i_data;
            r_wr_ptr                <= r_wr_ptr + (AW+1)'(1);
         end
         if (w_do_pop) begin
            r_rd_ptr <= r_rd_ptr + (AW+1)'(1);
         end
      end
   end

endmodule

// File: rtl/rosc_reader.sv
// Bus initiator that polls the ring-oscillator source, harvests entropy words into a FIFO
// and runs a repetition-count health test on the words it keeps.
module rosc_reader #(
   parameter int unsigned FIFO_DEPTH    = 4,
   parameter int unsigned POLL_GAP      = 16,
   parameter int unsigned DISCARD_WORDS = 1,
   parameter logic [7:0]  ADDR_STATUS   = rosc_pkg::ADDR_STATUS,
   parameter logic [7:0]  ADDR_ENTROPY  = rosc_pkg::ADDR_ENTROPY
) (
   input  logic                          clk,
   input  logic                          reset_n,
   input  logic                          enable,
   output logic                          cs,
   output logic                          we,
   output logic [7:0]                    address,
   output logic [31:0]                   write_data,
   input  logic [31:0]                   read_data,
   input  logic                          ready,
   output logic                          entropy_valid,
   output logic [31:0]                   entropy_data,
   input  logic                          entropy_ready,
   output logic [$clog2(FIFO_DEPTH):0]   fill_level,
   output logic                          repeat_error
);

   import rosc_pkg::*;

   localparam int unsigned LW        = $clog2(FIFO_DEPTH) + 1;
   localparam int unsigned GAP_W     = 8;
   localparam int unsigned DISC_W    = 4;
   localparam logic [GAP_W-1:0]  GAP_LOAD  = (POLL_GAP > 0) ? GAP_W'(POLL_GAP - 1) : '0;
   localparam logic [DISC_W-1:0] DISC_LOAD = DISC_W'(DISCARD_WORDS);

   rosc_state_t            r_state;
   logic                   r_cs;
   logic [ADDR_W-1:0]      r_address;
   logic [GAP_W-1:0]       r_gap_cnt;
   logic [DISC_W-1:0]      r_discard;
   logic                   r_enable_d;
   logic [DATA_W-1:0]      r_last_word;
   logic [REP_CNT_W-1:0]   r_rep_cnt;
   logic                   r_repeat_error;

   logic                   w_read_done;
   logic                   w_push;
   logic                   w_pop;
   logic                   w_empty;
   logic                   w_full;
   logic [DATA_W-1:0]      w_head;
   logic [LW-1:0]          w_level;

   assign cs            = r_cs;
   assign address       = r_address;
   assign we            = 1'b0;
   assign write_data    = '0;
   assign entropy_valid = !w_empty;
   assign entropy_data  = w_head;
   assign fill_level    = w_level;
   assign repeat_error  = r_repeat_error;

   assign w_read_done = (r_state == ST_READ) && r_cs && ready;
   assign w_push      = w_read_done && (r_discard == '0);
   assign w_pop       = !w_empty && entropy_ready;

   // Bus sequencer: every transaction is framed by at least one cs=0 cycle.
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         r_state   <= ST_IDLE;
         r_cs      <= 1'b0;
         r_address <= '0;
         r_gap_cnt <= '0;
      end else begin
         case (r_state)
            ST_IDLE: begin
               if (enable && !w_full) begin
                  r_state   <= ST_POLL;
                  r_cs      <= 1'b1;
                  r_address <= ADDR_STATUS;
               end
            end
            ST_POLL: begin
               if (ready) begin
                  r_cs <= 1'b0;
                  if (read_data[STATUS_READY_BIT]) begin
                     r_state <= ST_READ;
                  end else begin
                     r_state   <= ST_GAP;
                     r_gap_cnt <= GAP_LOAD;
                  end
               end
            end
            ST_GAP: begin
               if (!enable || (r_gap_cnt == '0)) begin
                  r_state <= ST_IDLE;
               end else begin
                  r_gap_cnt <= r_gap_cnt - GAP_W'(1);
               end
            end
            ST_READ: begin
               // First READ cycle is the mandatory idle gap after the STATUS poll.
               if (!r_cs) begin
                  r_cs      <= 1'b1;
                  r_address <= ADDR_ENTROPY;
               end else if (ready) begin
                  r_cs    <= 1'b0;
                  r_state <= ST_IDLE;
               end
            end
            default: begin
               r_state <= ST_IDLE;
               r_cs    <= 1'b0;
            end
         endcase
      end
   end

   // Start-up discard: reloads on reset and on every rising edge of enable.
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         r_enable_d <= 1'b0;
         r_discard  <= DISC_LOAD;
      end else begin
         r_enable_d <= enable;
         if (enable && !r_enable_d) begin
            r_discard <= DISC_LOAD;
         end else if (w_read_done && (r_discard != '0)) begin
            r_discard <= r_discard - DISC_W'(1);
         end
      end
   end

   // Repetition-count health test over kept words only.
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         r_last_word    <= '0;
         r_rep_cnt      <= '0;
         r_repeat_error <= 1'b0;
      end else if (w_push) begin
         r_last_word <= read_data;
         if (read_data == r_last_word) begin
            r_rep_cnt <= rep_cnt_next(r_rep_cnt);
            if (rep_trips(r_rep_cnt)) begin
               r_repeat_error <= 1'b1;
            end
         end else begin
            r_rep_cnt <= '0;
         end
      end
   end

   rosc_reader_fifo #(
      .DEPTH (FIFO_DEPTH),
      .WIDTH (DATA_W)
   ) u_fifo (
      .clk     (clk),
      .reset_n (reset_n),
      .i_push  (w_push),
      .i_data  (read_data),
      .i_pop   (w_pop),
      .o_data  (w_head),
      .o_empty (w_empty),
      .o_full  (w_full),
      .o_level (w_level)
   );

endmodule

// File: tb/tb_rosc_reader.sv
// Directed bench for rosc_reader with a behavioural entropy source and stream consumer.
module tb_rosc_reader;

   localparam logic [7:0] A_STATUS  = 8'h09;
   localparam logic [7:0] A_ENTROPY = 8'h20;

   logic        clk = 1'b0;
   logic        reset_n;
   logic        enable;
   logic        cs;
   logic        we;
   logic [7:0]  address;
   logic [31:0] write_data;
   logic [31:0] read_data;
   logic        ready;
   logic        entropy_valid;
   logic [31:0] entropy_data;
   logic        entropy_ready;
   logic [2:0]  fill_level;
   logic        repeat_error;

   // Source model controls (bench side) and state (model side)
   logic        stall;
   logic        cfg_load;
   int          cfg_zeros;
   int          cfg_reload;
   logic [31:0] words [32];
   int          st_zeros = 0;
   int          widx = 0;
   int          cyc = 0;
   int          n_polls = 0;
   int          n_reads = 0;
   int          read_polls = 0;
   int          poll_cyc [4096];
   logic [31:0] rx_q [1024];
   int          rx_n = 0;
   logic [2:0]  fill_max = '0;
   logic        done_prev = 1'b0;
   int          viol = 0;

   int n_vec = 0;
   int n_bad = 0;

   always #5 clk = ~clk;

   rosc_reader #(
      .FIFO_DEPTH    (4),
      .POLL_GAP      (4),
      .DISCARD_WORDS (1)
   ) dut (
      .clk           (clk),
      .reset_n       (reset_n),
      .enable        (enable),
      .cs            (cs),
      .we            (we),
      .address       (address),
      .write_data    (write_data),
      .read_data     (read_data),
      .ready         (ready),
      .entropy_valid (entropy_valid),
      .entropy_data  (entropy_data),
      .entropy_ready (entropy_ready),
      .fill_level    (fill_level),
      .repeat_error  (repeat_error)
   );

   assign ready = cs && !stall;

   always_comb begin
      if (address == A_STATUS) read_data = {31'b0, (st_zeros == 0)};
      else                     read_data = words[widx & 31];
   end

   always @(posedge clk) begin
      cyc       <= cyc + 1;
      done_prev <= cs && ready;
      if (cs && done_prev) viol <= viol + 1;
      if (entropy_valid && entropy_ready) begin
         rx_q[rx_n & 1023] <= entropy_data;
         rx_n <= rx_n + 1;
      end
      if (cfg_load) begin
         st_zeros <= cfg_zeros;
         widx     <= 0;
         fill_max <= '0;
      end else begin
         if (fill_level > fill_max) fill_max <= fill_level;
         if (cs && ready) begin
            if (address == A_STATUS) begin
               poll_cyc[n_polls & 4095] <= cyc;
               n_polls <= n_polls + 1;
               if (st_zeros > 0) st_zeros <= st_zeros - 1;
            end else if (address == A_ENTROPY) begin
               n_reads    <= n_reads + 1;
               widx       <= widx + 1;
               st_zeros   <= cfg_reload;
               read_polls <= n_polls;
            end
         end
      end
   end

   task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_vec++;
      if (got !== exp) begin
         n_bad++;
         $display("FAIL %s: got %h expected %h", tag, got, exp);
      end
   endtask

   task automatic load_src(input int zeros, input int reload, input logic [31:0] base);
      for (int i = 0; i < 32; i++) words[i] = base + 32'(i);
      cfg_zeros  = zeros;
      cfg_reload = reload;
      cfg_load   = 1'b1;
      @(negedge clk);
      cfg_load   = 1'b0;
   endtask

   task automatic wait_reads(input string tag, input int target);
      for (int i = 0; i < 1000 && n_reads < target; i++) @(negedge clk);
      chk(tag, 32'(n_reads >= target), 32'd1);
   endtask

   task automatic pop_one();
      entropy_ready = 1'b1;
      @(negedge clk);
      entropy_ready = 1'b0;
   endtask

   initial begin
      int p0, r0, rx0, cs_hi, k;
      reset_n = 1'b0; enable = 1'b0; entropy_ready = 1'b0; stall = 1'b0;
      cfg_load = 1'b0; cfg_zeros = 0; cfg_reload = 0;
      for (int i = 0; i < 32; i++) words[i] = '0;

      @(negedge clk);
      chk("rst_cs", 32'(cs), 32'd0);
      chk("rst_addr", 32'(address), 32'd0);
      chk("rst_we_wd", {31'b0, we} | write_data, 32'd0);
      chk("rst_valid", 32'(entropy_valid), 32'd0);
      chk("rst_fill", 32'(fill_level), 32'd0);
      chk("rst_rep_err", 32'(repeat_error), 32'd0);

      // Discard of the first word after reset
      load_src(0, 0, 32'h1111_1111);
      words[1] = 32'h2222_2222;
      reset_n = 1'b1; enable = 1'b1;
      wait_reads("disc_reads", 2);
      stall = 1'b1;
      @(negedge clk);
      chk("disc_fill", 32'(fill_level), 32'd1);
      chk("disc_head", entropy_data, 32'h2222_2222);
      pop_one();
      chk("disc_rx", rx_q[0], 32'h2222_2222);
      chk("disc_empty", 32'(fill_level), 32'd0);

      // Status polling: three not-ready answers, then ready
      load_src(3, 100000, 32'hA5A5_0001);
      p0 = n_polls; r0 = n_reads;
      stall = 1'b0;
      wait_reads("poll_read", r0 + 1);
      repeat (40) @(negedge clk);
      chk("poll_count", 32'(read_polls - p0), 32'd4);
      chk("poll_reads", 32'(n_reads - r0), 32'd1);
      for (int i = 0; i < 3; i++)
         chk("poll_spacing", 32'(poll_cyc[p0+i+1] - poll_cyc[p0+i]), 32'd6);
      chk("poll_head", entropy_data, 32'hA5A5_0001);
      chk("poll_fill", 32'(fill_level), 32'd1);
      pop_one();

      // Backpressure: FIFO fills to depth and the bus goes quiet
      stall = 1'b1;
      @(negedge clk);
      load_src(0, 0, 32'h3333_0000);
      r0 = n_reads;
      stall = 1'b0;
      wait_reads("full_reads", r0 + 4);
      repeat (30) @(negedge clk);
      chk("full_count", 32'(n_reads - r0), 32'd4);
      chk("full_fill", 32'(fill_level), 32'd4);
      cs_hi = 0;
      repeat (10) begin @(negedge clk); if (cs) cs_hi++; end
      chk("full_cs_idle", 32'(cs_hi), 32'd0);
      chk("full_head", entropy_data, 32'h3333_0000);
      pop_one();
      repeat (30) @(negedge clk);
      chk("refill_count", 32'(n_reads - r0), 32'd5);
      chk("refill_fill", 32'(fill_level), 32'd4);
      chk("refill_head", entropy_data, 32'h3333_0001);
      chk("full_rep_err", 32'(repeat_error), 32'd0);

      // Health test
      stall = 1'b1; entropy_ready = 1'b1;
      repeat (10) @(negedge clk);
      chk("drain_fill", 32'(fill_level), 32'd0);
      load_src(0, 0, 32'h5555_0000);
      words[0] = 32'hDEAD_BEEF; words[1] = 32'h0;
      words[2] = 32'hDEAD_BEEF; words[3] = 32'hDEAD_BEEF; words[4] = 32'hDEAD_BEEF;
      r0 = n_reads;
      stall = 1'b0;
      wait_reads("hlth_r3", r0 + 3);
      chk("hlth_split_ok", 32'(repeat_error), 32'd0);
      wait_reads("hlth_r4", r0 + 4);
      chk("hlth_two_ok", 32'(repeat_error), 32'd0);
      wait_reads("hlth_r5", r0 + 5);
      chk("hlth_three_err", 32'(repeat_error), 32'd1);
      wait_reads("hlth_continue", r0 + 7);

      // Streaming with consumer always ready: order kept, occupancy at most one
      stall = 1'b1;
      repeat (5) @(negedge clk);
      load_src(0, 0, 32'h6666_0000);
      rx0 = rx_n; r0 = n_reads;
      stall = 1'b0;
      wait_reads("strm_reads", r0 + 10);
      repeat (10) @(negedge clk);
      stall = 1'b1;
      repeat (5) @(negedge clk);
      chk("strm_fill_max", 32'(fill_max <= 3'd1), 32'd1);
      for (int i = 0; i < 10; i++)
         chk("strm_order", rx_q[(rx0 + i) & 1023], 32'h6666_0000 + 32'(i));
      chk("strm_rep_sticky", 32'(repeat_error), 32'd1);

      // Reset while an ENTROPY read is pending
      entropy_ready = 1'b0;
      load_src(0, 0, 32'h7777_0000);
      stall = 1'b0;
      k = 0;
      for (int i = 0; i < 200; i++) begin
         @(negedge clk);
         if (cs && address == A_ENTROPY && fill_level != 3'd0) begin
            stall = 1'b1; k = 1; break;
         end
      end
      chk("rrst_found_read", 32'(k), 32'd1);
      @(negedge clk);
      chk("rrst_cs_held", 32'(cs), 32'd1);
      #2 reset_n = 1'b0;
      #1;
      chk("rrst_cs_async", 32'(cs), 32'd0);
      chk("rrst_fill", 32'(fill_level), 32'd0);
      chk("rrst_valid", 32'(entropy_valid), 32'd0);
      chk("rrst_rep_err", 32'(repeat_error), 32'd0);
      @(negedge clk);
      load_src(0, 0, 32'h8888_0000);
      r0 = n_reads;
      reset_n = 1'b1; stall = 1'b0;
      k = 0;
      for (int i = 0; i < 20; i++) begin
         @(negedge clk);
         if (cs) begin k = 1; break; end
      end
      chk("rrst_first_cs", 32'(k), 32'd1);
      chk("rrst_first_addr", 32'(address), 32'(A_STATUS));
      wait_reads("rrst_reads", r0 + 2);
      chk("rrst_head", entropy_data, 32'h8888_0001);

      chk("no_back_to_back_cs", 32'(viol), 32'd0);

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
      $finish;
   end

endmodule
